snowv_fsm: RTL and testbench

SNOWV_FSM -- requirements
Module: snowv_fsm

---
 rtl/snowv_fsm.sv | 173 +++++++++++++++++
 tb/tb_snowv_fsm.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/snowv_fsm.sv
// SNOW-V FSM core: R1/R2/R3 update, LFSR step handshake, 16-step init and keystream output.
// Optional define SNOWV_FSM_KEYMIX_EN adds the 256-bit key port, folded into R1 on the last two init steps.

module snowv_aes_round (
    input  logic [127:0] i_state,
    output logic [127:0] o_state
);
    localparam logic [7:0] INV_EXP = 8'd254;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (so 0 maps to 0), then the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gf_mul(inv, inv);
            if (INV_EXP[i]) inv = gf_mul(inv, a);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [127:0] w_sb;

    always_comb begin
        w_sb = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                w_sb[8*(4*c + r) +: 8] = sbox(i_state[8*(4*((c + r) % 4) + r) +: 8]);
    end

    always_comb begin
        o_state = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o_state[8*(4*c + r) +: 8] = xtime(w_sb[8*(4*c + r) +: 8])
                                          ^ xtime(w_sb[8*(4*c + (r + 1) % 4) +: 8])
                                          ^ w_sb[8*(4*c + (r + 1) % 4) +: 8]
                                          ^ w_sb[8*(4*c + (r + 2) % 4) +: 8]
                                          ^ w_sb[8*(4*c + (r + 3) % 4) +: 8];
    end
endmodule

module snowv_fsm (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] t1,
    input  logic [127:0] t2,
    input  logic         t_valid,
    output logic         t_ready,
    output logic [127:0] fb_z,
    output logic         fb_en,
    output logic [127:0] ks,
    output logic         ks_valid,
    input  logic         ks_ready,
    output logic         busy
`ifdef SNOWV_FSM_KEYMIX_EN
    ,
    input  logic [255:0] key
`endif
);
    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_RUN} state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_r1, r_r2, r_r3;
    logic [127:0] r_ks;
    logic         r_ks_valid;
    logic [3:0]   r_cnt;
    logic [127:0] w_z, w_r1_step, w_r1_nxt, w_aes_r1, w_aes_r2;
    logic         w_accept;

    // Four independent 32-bit additions; no carry crosses a lane boundary.
    function automatic logic [127:0] lane_add(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] s;
        for (int j = 0; j < 4; j++) s[32*j +: 32] = a[32*j +: 32] + b[32*j +: 32];
        return s;
    endfunction

    function automatic logic [127:0] sigma(input logic [127:0] a);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = a[8*(4*(i % 4) + i / 4) +: 8];
        return o;
    endfunction

    snowv_aes_round u_aes_r1 (.i_state(r_r1), .o_state(w_aes_r1));
    snowv_aes_round u_aes_r2 (.i_state(r_r2), .o_state(w_aes_r2));

    assign w_z       = lane_add(r_r1, t1) ^ r_r2;
    assign w_r1_step = sigma(lane_add(r_r2, r_r3 ^ t2));
    assign t_ready   = (r_state == ST_INIT) || ((r_state == ST_RUN) && (!r_ks_valid || ks_ready));
    assign w_accept  = t_valid && t_ready;
    assign fb_z      = w_z;
    assign fb_en     = (r_state == ST_INIT);
    assign busy      = (r_state != ST_IDLE);
    assign ks        = r_ks;
    assign ks_valid  = r_ks_valid;

`ifdef SNOWV_FSM_KEYMIX_EN
    always_comb begin
        w_r1_nxt = w_r1_step;
        if (r_state == ST_INIT && r_cnt == 4'd14)      w_r1_nxt = w_r1_step ^ key[127:0];
        else if (r_state == ST_INIT && r_cnt == 4'd15) w_r1_nxt = w_r1_step ^ key[255:128];
    end
`else
    assign w_r1_nxt = w_r1_step;
`endif

    // NOTE: next state is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_INIT;
            ST_INIT: begin
                if (start)                              w_state_nxt = ST_INIT;
                else if (w_accept && r_cnt == 4'd15)    w_state_nxt = ST_RUN;
            end
            ST_RUN:  if (start) w_state_nxt = ST_INIT;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_r1       <= '0;
            r_r2       <= '0;
            r_r3       <= '0;
            r_cnt      <= '0;
            r_ks       <= '0;
            r_ks_valid <= 1'b0;
        end else if (start) begin
            // A step presented together with start is dropped.
            r_r1       <= '0;
            r_r2       <= '0;
            r_r3       <= '0;
            r_cnt      <= '0;
            r_ks_valid <= 1'b0;
        end else if (w_accept) begin
            r_r1 <= w_r1_nxt;
            r_r2 <= w_aes_r1;
            r_r3 <= w_aes_r2;
            if (r_state == ST_INIT) r_cnt <= r_cnt + 4'd1;
            if (r_state == ST_RUN) begin
                r_ks       <= w_z;
                r_ks_valid <= 1'b1;
            end
        end else if (ks_ready) begin
            r_ks_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_snowv_fsm.sv
// Self-checking bench for snowv_fsm: cycle model of the FSM plus a keystream scoreboard queue.
// Build with SNOWV_FSM_KEYMIX_EN defined to exercise the key-mixing variant.
`timescale 1ns/1ps
module tb_snowv_fsm;
    localparam int S_IDLE = 0;
    localparam int S_INIT = 1;
    localparam int S_RUN  = 2;
    localparam logic [127:0] ALL63 = {16{8'h63}};

    logic         clk = 1'b0;
    logic         rst, start, t_valid, t_ready, fb_en, ks_valid, ks_ready, busy;
    logic [127:0] t1, t2, fb_z, ks;
`ifdef SNOWV_FSM_KEYMIX_EN
    logic [255:0] key;
`endif

    always #5 clk = ~clk;

    snowv_fsm dut (
        .clk(clk), .rst(rst), .start(start), .t1(t1), .t2(t2),
        .t_valid(t_valid), .t_ready(t_ready), .fb_z(fb_z), .fb_en(fb_en),
        .ks(ks), .ks_valid(ks_valid), .ks_ready(ks_ready), .busy(busy)
`ifdef SNOWV_FSM_KEYMIX_EN
        , .key(key)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference arithmetic, written independently of the RTL.
    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 0; x = a; y = b;
        while (y != 0) begin
            if (y[0]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] s);
        logic [7:0]   a [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            int row, col;
            row = i % 4; col = i / 4;
            a[i] = sb[s[8*(row + 4*((col + row) % 4)) +: 8]];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(4*c + r) +: 8] = gmul(8'd2, a[4*c + r]) ^ gmul(8'd3, a[4*c + (r + 1) % 4])
                                    ^ a[4*c + (r + 2) % 4] ^ a[4*c + (r + 3) % 4];
        return o;
    endfunction

    function automatic logic [127:0] add_ref(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] o;
        for (int j = 0; j < 4; j++) o[32*j +: 32] = a[32*j +: 32] + b[32*j +: 32];
        return o;
    endfunction

    function automatic logic [127:0] sigma_ref(input logic [127:0] a);
        int p [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = a[8*p[i] +: 8];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Model state and scoreboard.
    int           m_state;
    logic [3:0]   m_cnt;
    logic [127:0] m_r1, m_r2, m_r3;
    logic         m_ksv;
    bit           m_known = 0;
    logic [127:0] exp_q [$];
    int           fb_en_cnt = 0;
    logic [127:0] obs_fbz;

    task automatic cycle(input bit r, input bit st, input bit tv, input bit kr,
                         input logic [127:0] a1, input logic [127:0] a2);
        logic         exp_tr;
        logic [127:0] z, n1, n2, n3;
        rst = r; start = st; t_valid = tv; ks_ready = kr; t1 = a1; t2 = a2;
        #1;
        exp_tr = (m_state == S_INIT) || (m_state == S_RUN && (!m_ksv || kr));
        z      = add_ref(m_r1, a1) ^ m_r2;
        if (m_known) begin
            check("t_ready", 128'(t_ready), 128'(exp_tr));
            check("fb_en", 128'(fb_en), 128'(m_state == S_INIT));
            check("busy", 128'(busy), 128'(m_state != S_IDLE));
            check("ks_valid", 128'(ks_valid), 128'(m_ksv));
            check("fb_z", fb_z, z);
            if (fb_en) fb_en_cnt++;
            if (ks_valid && kr) begin
                if (exp_q.size() == 0) check("ks_unexpected", 128'(ks_valid), 128'(0));
                else                   check("ks_word", ks, exp_q.pop_front());
            end
        end
        obs_fbz = fb_z;
        if (r) begin
            m_known = 1; m_state = S_IDLE; m_cnt = 0; m_ksv = 0;
            m_r1 = 0; m_r2 = 0; m_r3 = 0; exp_q.delete();
        end else if (st) begin
            m_state = S_INIT; m_cnt = 0; m_ksv = 0;
            m_r1 = 0; m_r2 = 0; m_r3 = 0; exp_q.delete();
        end else if (tv && exp_tr) begin
            n1 = sigma_ref(add_ref(m_r2, m_r3 ^ a2));
`ifdef SNOWV_FSM_KEYMIX_EN
            if (m_state == S_INIT && m_cnt == 14)      n1 ^= key[127:0];
            else if (m_state == S_INIT && m_cnt == 15) n1 ^= key[255:128];
`endif
            n2 = aes_ref(m_r1);
            n3 = aes_ref(m_r2);
            if (m_state == S_RUN) begin
                exp_q.push_back(z);
                m_ksv = 1;
            end
            if (m_state == S_INIT) begin
                if (m_cnt == 15) m_state = S_RUN;
                m_cnt++;
            end
            m_r1 = n1; m_r2 = n2; m_r3 = n3;
        end else if (kr) begin
            m_ksv = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_r1"}, dut.r_r1, m_r1);
        check({tag, "_r2"}, dut.r_r2, m_r2);
        check({tag, "_r3"}, dut.r_r3, m_r3);
        check({tag, "_cnt"}, 128'(dut.r_cnt), 128'(m_cnt));
    endtask

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, s;
            inv = 0;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int b = 0; b < 8; b++)
                s[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8] ^ inv[(b + 6) % 8]
                     ^ inv[(b + 7) % 8] ^ ((8'h63 >> b) & 8'h01) != 0;
            sb[x] = s;
        end
        m_state = S_IDLE; m_cnt = 0; m_r1 = 0; m_r2 = 0; m_r3 = 0; m_ksv = 0;
        rst = 1; start = 0; t_valid = 0; ks_ready = 0; t1 = 0; t2 = 0;
`ifdef SNOWV_FSM_KEYMIX_EN
        key = '1;
`endif
        @(negedge clk);

        // Reset wins over start and handshake; outputs idle during and after reset.
        cycle(1, 1, 1, 1, rnd128(), rnd128());
        cycle(1, 1, 1, 1, rnd128(), rnd128());
        cycle(0, 0, 1, 1, rnd128(), rnd128());
        check("ks_after_rst", ks, 128'(0));
        check_regs("idle");

        // Known-answer steps; the third proves lanes do not carry into each other.
        cycle(0, 1, 0, 0, 128'(0), 128'(0));
        fb_en_cnt = 0;
        cycle(0, 0, 1, 1, 128'(0), 128'(0));
        check("kat1_fbz", obs_fbz, 128'(0));
        check("kat1_r1", dut.r_r1, 128'(0));
        check("kat1_r2", dut.r_r2, ALL63);
        check("kat1_r3", dut.r_r3, ALL63);
        cycle(0, 0, 1, 1, 128'(0), ALL63);
        check("kat2_fbz", obs_fbz, ALL63);
        check("kat2_r1", dut.r_r1, ALL63);
        cycle(0, 0, 1, 1, {4{32'h9C9C9C9D}}, rnd128());
        check("kat3_fbz", obs_fbz, ALL63);
        for (int i = 0; i < 13; i++) begin
            cycle(0, 0, 1, 1, rnd128(), rnd128());
            if (i == 11) check("r1_step15", dut.r_r1, m_r1);
            if (i == 12) check("r1_step16", dut.r_r1, m_r1);
        end

        // RUN: stream, stall with ks_ready low, then one word per cycle again.
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, rnd128(), rnd128());
        check("fb_en_cycles", 128'(fb_en_cnt), 128'(16));
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, 0, rnd128(), rnd128());
            check_regs("stall");
            check("stall_ks", ks, exp_q[0]);
        end
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 1, rnd128(), rnd128());
        for (int i = 0; i < 40; i++)
            cycle(0, 0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0), rnd128(), rnd128());
        cycle(0, 0, 0, 1, rnd128(), rnd128());

        // Restart from RUN, then restart again at cnt==7 with a colliding step.
        cycle(0, 1, 1, 1, rnd128(), rnd128());
        check_regs("restart_run");
        for (int i = 0; i < 8; i++) cycle(0, 0, i != 3, 1, rnd128(), rnd128());
        check("cnt_before_restart", 128'(dut.r_cnt), 128'(7));
        cycle(0, 1, 1, 1, rnd128(), rnd128());
        check_regs("restart_init");
        check("restart_cnt", 128'(dut.r_cnt), 128'(0));
        for (int i = 0; i < 22; i++) cycle(0, 0, 1, bit'($urandom_range(0, 1)), rnd128(), rnd128());

        // Reset mid-RUN with start and handshake active.
        cycle(1, 1, 1, 1, rnd128(), rnd128());
        cycle(0, 0, 1, 1, rnd128(), rnd128());
        check("ks_after_rst2", ks, 128'(0));
        check_regs("rst_run");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
